// File: rtl/wfg_drive_pat_pkg.sv
// Shared types and sizing helpers for the buffered pattern driver.
package wfg_drive_pat_pkg;

  // Per-channel drive mode, two bits per channel in cfg_mode_i.
  typedef enum logic [1:0] {
    OFF  = 2'b00,
    PAT  = 2'b01,
    INV  = 2'b10,
    HIGH = 2'b11
  } drive_mode_e;

  localparam int unsigned AXIS_DATA_WIDTH_DEF = 32;

  // FIFO entry: pattern word plus its tlast flag in the MSB.
  localparam int unsigned FIFO_ENTRY_WIDTH = AXIS_DATA_WIDTH_DEF + 1;

  function automatic int unsigned entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/wfg_drive_pat_fifo.sv
// Synchronous FIFO with explicit level tracking, flush and guarded push/pop.
module wfg_drive_pat_fifo
  import wfg_drive_pat_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_ENTRY_WIDTH,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = level_q;

  // Storage array; contents are only observable while level > 0, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; level disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/wfg_drive_pat_seq.sv
// Buffered per-channel pattern driver: stream FIFO, sub-cycle step, mode mux.
module wfg_drive_pat_seq
  import wfg_drive_pat_pkg::*;
#(
  parameter int unsigned CHANNELS        = 32,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned DEPTH           = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        ctrl_en_i,
  input  logic [2*CHANNELS-1:0]       cfg_mode_i,
  input  logic [7:0]                  cfg_subcycle_i,
  input  logic                        underrun_clr_i,
  input  logic                        wfg_core_sync_i,
  input  logic [7:0]                  wfg_core_subcycle_cnt_i,
  output logic                        wfg_axis_tready_o,
  input  logic                        wfg_axis_tvalid_i,
  input  logic                        wfg_axis_tlast_i,
  input  logic [AXIS_DATA_WIDTH-1:0]  wfg_axis_tdata_i,
  output logic [CHANNELS-1:0]         pat_dout_o,
  output logic [CHANNELS-1:0]         pat_dout_en_o,
  output logic [$clog2(DEPTH):0]      fifo_level_o,
  output logic                        underrun_o,
  output logic                        frame_end_o
);

  localparam int unsigned EW = entry_width(AXIS_DATA_WIDTH);

  logic [EW-1:0]              head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       step;
  logic                       pop;
  logic                       underrun_set;

  logic [AXIS_DATA_WIDTH-1:0] pat_q;
  logic                       last_q;
  logic                       pop_q;
  logic                       frame_end_q;
  logic                       underrun_q;
  logic [CHANNELS-1:0]        dout_q;
  logic [CHANNELS-1:0]        en_q;
  logic [CHANNELS-1:0]        dout_c;
  logic [CHANNELS-1:0]        en_c;

  // Ready depends only on enable, reset and stored level, never on tvalid.
  assign wfg_axis_tready_o = ctrl_en_i && !wb_rst_i && !fifo_full;
  assign push              = wfg_axis_tvalid_i && wfg_axis_tready_o;
  assign step              = ctrl_en_i && wfg_core_sync_i &&
                             (wfg_core_subcycle_cnt_i == cfg_subcycle_i);
  assign pop               = step && !fifo_empty;
  assign underrun_set      = step && fifo_empty;

  wfg_drive_pat_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (!ctrl_en_i),
    .push  (push),
    .pop   (pop),
    .din   ({wfg_axis_tlast_i, wfg_axis_tdata_i}),
    .dout  (head),
    .level (fifo_level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-channel mode mux from the applied pattern word.
  always_comb begin
    dout_c = '0;
    en_c   = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      case (drive_mode_e'(cfg_mode_i[2*c +: 2]))
        PAT: begin
          dout_c[c] = pat_q[c];
          en_c[c]   = 1'b1;
        end
        INV: begin
          dout_c[c] = ~pat_q[c];
          en_c[c]   = 1'b1;
        end
        HIGH: begin
          dout_c[c] = 1'b1;
          en_c[c]   = 1'b1;
        end
        default: begin
          dout_c[c] = 1'b0;
          en_c[c]   = 1'b0;
        end
      endcase
    end
  end

  // Pattern register, pins, frame-end pulse and sticky underrun.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pat_q       <= '0;
      last_q      <= 1'b0;
      pop_q       <= 1'b0;
      frame_end_q <= 1'b0;
      underrun_q  <= 1'b0;
      dout_q      <= '0;
      en_q        <= '0;
    end else begin
      if (underrun_set) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr_i) begin
        underrun_q <= 1'b0;
      end

      if (!ctrl_en_i) begin
        pat_q       <= '0;
        last_q      <= 1'b0;
        pop_q       <= 1'b0;
        frame_end_q <= 1'b0;
        dout_q      <= '0;
        en_q        <= '0;
      end else begin
        if (pop) begin
          pat_q  <= head[AXIS_DATA_WIDTH-1:0];
          last_q <= head[EW-1];
        end
        pop_q       <= pop;
        frame_end_q <= pop_q && last_q;
        dout_q      <= dout_c;
        en_q        <= en_c;
      end
    end
  end

  assign pat_dout_o    = dout_q;
  assign pat_dout_en_o = en_q;
  assign underrun_o    = underrun_q;
  assign frame_end_o   = frame_end_q;

endmodule

// File: doc/wfg_drive_pat_seq.md
# wfg_drive_pat_seq

Buffered, per-channel-configurable successor of the pattern driver. It accepts pattern words over AXI-Stream into an internal FIFO of parametrised depth, and pops one word per selected core sub-cycle. It drives `CHANNELS` output pins, each in its own mode (off, pattern, inverted pattern, static high), and reports fill level, underrun and frame end. It sits between the waveform-generator core sync/AXI-Stream fabric and the pad ring; configuration comes from the block's Wishbone register file as plain ports.

## Interface
Parameters:
- `CHANNELS`, 32: number of output pins; must be ≤ `AXIS_DATA_WIDTH`.
- `AXIS_DATA_WIDTH`, 32: stream word width; channel c takes bit c.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥ 2.

Ports (one clock `wb_clk_i`; reset `wb_rst_i` is synchronous, active-high):
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: synchronous active-high reset.
- `ctrl_en_i` in 1: block enable; low flushes the FIFO and blanks the outputs.
- `cfg_mode_i` in 2*CHANNELS: mode of channel c in bits [2c+1:2c]. 00 = off, 01 = pattern, 10 = inverted, 11 = static high.
- `cfg_subcycle_i` in 8: sub-cycle on which a word is applied.
- `underrun_clr_i` in 1: clears `underrun_o`.
- `wfg_core_sync_i` in 1: core sync pulse.
- `wfg_core_subcycle_cnt_i` in 8: core sub-cycle counter.
- `wfg_axis_tready_o` out 1: stream ready.
- `wfg_axis_tvalid_i` in 1: stream valid.
- `wfg_axis_tlast_i` in 1: stream last; marks the frame end.
- `wfg_axis_tdata_i` in AXIS_DATA_WIDTH: pattern word.
- `pat_dout_o` out CHANNELS: pin values.
- `pat_dout_en_o` out CHANNELS: pin output enables.
- `fifo_level_o` out $clog2(DEPTH)+1: words currently stored.
- `underrun_o` out 1: sticky; set when a step finds the FIFO empty.
- `frame_end_o` out 1: one-cycle pulse when a word tagged tlast is applied.

## Operation
- **Push:** `wfg_axis_tready_o` = `ctrl_en_i` && level != DEPTH, decoded from registered state (no combinational path from tvalid). A word and its tlast are written when tvalid && tready.
- **Step:** step = `ctrl_en_i` && `wfg_core_sync_i` && (`wfg_core_subcycle_cnt_i` == `cfg_subcycle_i`).
  - If level > 0: pop the head into the pattern register `pat_q` and its last flag into `last_q`.
  - If level == 0: `pat_q` holds its value and `underrun_o` sets.
- **Output, per channel (registered):**
  - off: dout 0, en 0.
  - pattern: dout `pat_q[c]`, en 1.
  - inverted: dout `~pat_q[c]`, en 1.
  - static high: dout 1, en 1.
- **Simultaneous push and pop:** both happen; level is unchanged.
- **Full:** no push, even if a pop occurs in the same cycle (no full bypass).
- **Empty plus push and step in the same cycle:** no bypass. The step is an underrun and the pushed word is stored.
- **Underrun clear:** `underrun_clr_i` clears the flag. A set in the same cycle wins.
- **Disable (`ctrl_en_i` low):** next edge sets level = 0 and pointers = 0, and clears `pat_q`, `last_q` and all outputs. `underrun_o` is retained.
- **Wrap-around:** pointers are $clog2(DEPTH) bits and wrap naturally. Level is tracked separately so full and empty are unambiguous.

## Timing
- **Reset values:** `wfg_axis_tready_o` 0, `pat_dout_o` 0, `pat_dout_en_o` 0, `fifo_level_o` 0, `underrun_o` 0, `frame_end_o` 0. The FIFO and `pat_q` are cleared.
- **Push latency:** a word accepted at edge N is visible in `fifo_level_o` after edge N. It is poppable by a step in cycle N+1.
- **Step to pins:** step in cycle N → `pat_q` updated at edge N → pins change at edge N+1, i.e. visible in cycle N+2. `frame_end_o` pulses in that same cycle N+2.
- **Mode change:** a `cfg_mode_i` change in cycle N is reflected on the pins in cycle N+1.
- **Reset mid-operation:** all state returns to reset values at the next edge, including a partially filled FIFO.

## Structure
- Package `wfg_drive_pat_pkg` holds:
  - enum typedef `drive_mode_e` (OFF, PAT, INV, HIGH);
  - localparam for the FIFO entry width (AXIS_DATA_WIDTH+1).
- Sub-module `wfg_drive_pat_fifo`: synchronous FIFO with push, pop, level, flush and data+last storage.
- The top level contains the step decode, `pat_q` and `last_q`, the per-channel mode mux, output registers and flags.

## Test plan
- **Basic apply:** reset, enable, all channels PAT, `cfg_subcycle_i` = 3. Push 0xA5A5_0F0F, then sync with subcnt 3 → `pat_dout_o` = 0xA5A5_0F0F and `pat_dout_en_o` = all ones, 2 cycles after the step.
- **Modes:** ch0 OFF, ch1 INV, ch2 HIGH, rest PAT; apply word 0x0000_0007 → bits[2:0] of dout = 3'b100, en[2:0] = 3'b110.
- **Full:** hold tvalid and push DEPTH words with no steps → level = DEPTH and tready = 0. One step → level = DEPTH-1, then tready = 1.
- **Underrun:** step with an empty FIFO → pins hold the previous word and `underrun_o` = 1. Pulse `underrun_clr_i` → 0. A concurrent step underrun during clear → stays 1.
- **Frame end:** push 4 words with tlast on the 4th and step 4 times → exactly one `frame_end_o` pulse, 2 cycles after the 4th step. Step with subcnt ≠ `cfg_subcycle_i` → no pop.
- **Disable and reset:** fill 5 words, drop `ctrl_en_i` → level 0 and outputs 0 next cycle. Repeat with `wb_rst_i` mid-stream → all outputs at reset values.
